// File: rtl/mock8080_pkg.sv
// ---------------------------------------------------------------------------
// mock8080_pkg
// Shared definitions for the RAM responder slice: default geometry and the
// loader/clear FSM state encoding (2-bit legacy-compatible constants).
// ---------------------------------------------------------------------------
package mock8080_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // FSM state encoding, also visible on the responder's fsm_state output.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/module_ram_responder_if.sv
// ---------------------------------------------------------------------------
// module_ram_responder_if
// Groups the CPU data-bus signals and the loader stream signals.
//   master : the CPU / loader side (drives requests and bytes)
//   slave  : the RAM responder
//
// Loader handshake: a byte transfers on every rising clk_qzt edge where
// ld_valid and ld_ready are both high. While ld_valid is high and ld_ready
// is low, ld_data must stay stable. ld_ready is decoded from the FSM state
// and does not depend on ld_valid.
// ---------------------------------------------------------------------------
interface module_ram_responder_if
    import mock8080_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // CPU data bus
    logic              cpu_tick;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;

    // Loader / clear control and byte stream
    logic              ld_start;
    logic              ld_clear;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_done;

    modport master (
        output cpu_tick, cpu_addr, cpu_wdata, cpu_we,
        input  cpu_rdata, cpu_hold,
        output ld_start, ld_clear, ld_base, ld_len, ld_data, ld_valid,
        input  ld_ready, ld_done
    );

    modport slave (
        input  cpu_tick, cpu_addr, cpu_wdata, cpu_we,
        output cpu_rdata, cpu_hold,
        input  ld_start, ld_clear, ld_base, ld_len, ld_data, ld_valid,
        output ld_ready, ld_done
    );

endinterface

// File: rtl/module_ram_responder_ram_sp_array.sv
// ---------------------------------------------------------------------------
// ram_sp_array
// Single-port synchronous memory: one write port and one registered read,
// sharing a single address.
//   clk_qzt, reset : clock, async active-high reset (read register only)
//   we             : write wdata to mem[addr]
//   re             : update rdata; write-first when we is also high
//   addr, wdata    : shared address / write data
//   rdata          : registered read data, holds when re is low
// Memory contents are never reset.
// ---------------------------------------------------------------------------
module ram_sp_array
    import mock8080_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_qzt,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_qzt) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/module_ram_responder.sv
// ---------------------------------------------------------------------------
// module_ram_responder
// Memory-side responder for the CPU data bus. Serves CPU reads/writes on
// cpu_tick while idle, and runs a loader (byte stream to ld_base..) or a
// full-memory clear, holding the CPU off while busy.
//   clk_qzt   : system clock
//   reset     : asynchronous, active-high reset
//   bus       : module_ram_responder_if.slave (CPU bus + loader stream)
//   fsm_state : current FSM state (ST_* encoding from mock8080_pkg)
// ---------------------------------------------------------------------------
module module_ram_responder
    import mock8080_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk_qzt,
    input  logic                   reset,
    module_ram_responder_if.slave  bus,
    output logic [1:0]             fsm_state
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Port mux: the CPU owns the array only in IDLE; the loader and the
    // clear engine drive it from the internal pointer otherwise. The read
    // register only moves on accepted CPU ticks, so it holds while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = bus.cpu_addr;
        mem_wdata = bus.cpu_wdata;
        case (state)
            ST_IDLE: begin
                mem_we = bus.cpu_tick & bus.cpu_we;
                mem_re = bus.cpu_tick;
            end
            ST_LOAD: begin
                mem_we    = bus.ld_valid;
                mem_addr  = ptr;
                mem_wdata = bus.ld_data;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = '0;
            end
            default: begin
            end
        endcase
    end

    ram_sp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_qzt (clk_qzt),
        .reset   (reset),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Clear has priority; a simultaneous ld_start is dropped.
                    if (bus.ld_clear) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end else if (bus.ld_start) begin
                        if (bus.ld_len != CNT_ZERO) begin
                            state <= ST_LOAD;
                            ptr   <= bus.ld_base;
                            cnt   <= bus.ld_len;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        ptr <= ptr + 1'b1;   // wraps modulo 2^ADDR_W
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = mem_rdata;
    assign bus.cpu_hold  = (state != ST_IDLE);
    assign bus.ld_ready  = (state == ST_LOAD);
    assign bus.ld_done   = (state == ST_DONE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_module_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_module_ram_responder
// Directed bench for module_ram_responder. CPU ticks push their expected
// cpu_rdata into exp_q; a negedge monitor pops and compares after each
// accepted tick edge. Loader, clear and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_module_ram_responder;
    import mock8080_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk_qzt = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_qzt = ~clk_qzt;

    module_ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [1:0] fsm_state;

    module_ram_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_qzt   (clk_qzt),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    logic tick_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk_qzt or posedge reset) begin
        if (reset) tick_seen <= 1'b0;
        else       tick_seen <= bus.cpu_tick;
    end

    always @(negedge clk_qzt) begin
        logic [DW-1:0] e;
        if (bus.ld_done === 1'b1) done_cnt++;
        if (tick_seen) begin
            if (exp_q.size() == 0) begin
                check("rsp_without_expectation", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_op(input logic [7:0] a, input logic w, input logic [7:0] d,
                          input logic [7:0] e);
        @(negedge clk_qzt);
        bus.cpu_addr  = a;
        bus.cpu_we    = w;
        bus.cpu_wdata = d;
        bus.cpu_tick  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk_qzt);
        bus.cpu_tick  = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic ld_go(input logic [7:0] base, input logic [8:0] len);
        @(negedge clk_qzt);
        bus.ld_base  = base;
        bus.ld_len   = len;
        bus.ld_start = 1'b1;
        @(negedge clk_qzt);
        bus.ld_start = 1'b0;
    endtask

    // Returns just after the edge that accepted the byte.
    task automatic ld_byte(input logic [7:0] d, input int gap);
        int k;
        repeat (gap) begin
            @(negedge clk_qzt);
            bus.ld_valid = 1'b0;
        end
        @(negedge clk_qzt);
        bus.ld_data  = d;
        bus.ld_valid = 1'b1;
        k = 0;
        while (bus.ld_ready !== 1'b1 && k < 50) begin
            @(negedge clk_qzt);
            k++;
        end
        if (k >= 50) check("ld_accept_timeout", 32'd0, 32'd1);
        else         @(posedge clk_qzt);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_qzt);
            bus.ld_valid = 1'b0;
            cycles++;
        end while (bus.ld_done !== 1'b1 && cycles < budget);
        if (bus.ld_done !== 1'b1) check("ld_done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int d0;
        logic [7:0] av;

        bus.cpu_tick = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_we = 0;
        bus.ld_start = 0; bus.ld_clear = 0; bus.ld_base = 0; bus.ld_len = 0;
        bus.ld_data = 0;  bus.ld_valid = 0;

        // Reset values
        repeat (3) @(negedge clk_qzt);
        check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        check("rst_cpu_hold",  {31'd0, bus.cpu_hold}, 32'd0);
        check("rst_ld_ready",  {31'd0, bus.ld_ready}, 32'd0);
        check("rst_ld_done",   {31'd0, bus.ld_done},  32'd0);
        reset = 1'b0;
        @(negedge clk_qzt);
        check("post_rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});

        // Load C3,20,00 at 0x10 with a 2-cycle valid gap
        d0 = done_cnt;
        ld_go(8'h10, 9'd3);
        check("load_state", {30'd0, fsm_state}, {30'd0, ST_LOAD});
        check("load_hold",  {31'd0, bus.cpu_hold}, 32'd1);
        check("load_ready", {31'd0, bus.ld_ready}, 32'd1);
        ld_byte(8'hC3, 0);
        ld_byte(8'h20, 2);
        ld_byte(8'h00, 0);
        wait_done(20, cyc);
        check("load_done_latency", cyc, 32'd1);
        check("load_hold_in_done", {31'd0, bus.cpu_hold}, 32'd1);
        @(negedge clk_qzt);
        #1;
        check("load_hold_after",   {31'd0, bus.cpu_hold}, 32'd0);
        check("load_done_pulse",   {31'd0, bus.ld_done}, 32'd0);
        check("load_done_count",   done_cnt - d0, 32'd1);
        cpu_op(8'h10, 1'b0, 8'h00, 8'hC3);
        cpu_op(8'h11, 1'b0, 8'h00, 8'h20);
        cpu_op(8'h12, 1'b0, 8'h00, 8'h00);

        // CPU write-first then read-back
        cpu_op(8'h40, 1'b1, 8'h5A, 8'h5A);
        cpu_op(8'h40, 1'b0, 8'h00, 8'h5A);

        // Ticks during LOAD are ignored; cpu_rdata holds at 5A
        ld_go(8'h30, 9'd1);
        cpu_op(8'h40, 1'b1, 8'h77, 8'h5A);
        cpu_op(8'h10, 1'b0, 8'h00, 8'h5A);
        ld_byte(8'h99, 0);
        wait_done(20, cyc);
        cpu_op(8'h40, 1'b0, 8'h00, 8'h5A);
        cpu_op(8'h30, 1'b0, 8'h00, 8'h99);

        // Pointer wrap
        ld_go(8'hFE, 9'd4);
        ld_byte(8'h01, 0);
        ld_byte(8'h02, 0);
        ld_byte(8'h03, 1);
        ld_byte(8'h04, 0);
        wait_done(20, cyc);
        cpu_op(8'hFE, 1'b0, 8'h00, 8'h01);
        cpu_op(8'hFF, 1'b0, 8'h00, 8'h02);
        cpu_op(8'h00, 1'b0, 8'h00, 8'h03);
        cpu_op(8'h01, 1'b0, 8'h00, 8'h04);

        // Simultaneous clear + start: clear wins
        d0 = done_cnt;
        @(negedge clk_qzt);
        bus.ld_clear = 1'b1; bus.ld_start = 1'b1; bus.ld_base = 8'h00; bus.ld_len = 9'd5;
        @(negedge clk_qzt);
        bus.ld_clear = 1'b0; bus.ld_start = 1'b0;
        check("clear_state", {30'd0, fsm_state}, {30'd0, ST_CLEAR});
        wait_done(300, cyc);
        check("clear_cycles", cyc, 32'd256);
        repeat (4) @(negedge clk_qzt);
        #1;
        check("clear_then_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        check("clear_done_count", done_cnt - d0, 32'd1);
        for (int a = 0; a < 256; a++) begin
            av = a[7:0];
            cpu_op(av, 1'b0, 8'h00, 8'h00);
        end

        // Zero-length load
        d0 = done_cnt;
        ld_go(8'h20, 9'd0);
        check("len0_state", {30'd0, fsm_state}, {30'd0, ST_DONE});
        check("len0_done",  {31'd0, bus.ld_done}, 32'd1);
        @(negedge clk_qzt);
        #1;
        check("len0_idle",       {30'd0, fsm_state}, {30'd0, ST_IDLE});
        check("len0_done_count", done_cnt - d0, 32'd1);
        cpu_op(8'h20, 1'b0, 8'h00, 8'h00);

        // Reset after 2 of 5 bytes, asserted mid-cycle
        cpu_op(8'h50, 1'b1, 8'h66, 8'h66);
        d0 = done_cnt;
        ld_go(8'h80, 9'd5);
        ld_byte(8'hAA, 0);
        ld_byte(8'hBB, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        check("mid_rst_hold",  {31'd0, bus.cpu_hold}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ld_ready}, 32'd0);
        check("mid_rst_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        bus.ld_valid = 1'b0;
        @(negedge clk_qzt);
        reset = 1'b0;
        repeat (3) @(negedge clk_qzt);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 32'd0);
        check("mid_rst_idle",    {30'd0, fsm_state}, {30'd0, ST_IDLE});
        cpu_op(8'h80, 1'b0, 8'h00, 8'hAA);
        cpu_op(8'h81, 1'b0, 8'h00, 8'hBB);
        cpu_op(8'h82, 1'b0, 8'h00, 8'h00);

        // Final report
        repeat (3) @(negedge clk_qzt);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
